chs_slot_scheduler: RTL and testbench
=====================================

# chs_slot_scheduler

Time-slice scheduler that shares one channel mode/power decoder between NCH channel configurations. Holds one 8-bit configuration per channel, written over a simple write/ack port, and presents them round-robin on `chs_conf` to the shared decoder. Samples the decoder's `chs_power` result and checks it against a power limit. Sits between the house configuration registers and the decoder; downstream logic qualifies the decoder outputs with `chs_valid`/`chs_sel`.

## Interface
- `NCH`, default 4: number of channels (power of two, 2..16).
- `DWELL`, default 16: cycles a channel is held in RUN (1..255).
- `clk` input 1: clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: scheduler enable.
- `cfg_wr` input 1: configuration write strobe.
- `cfg_ch` input log2(NCH): channel index for the write.
- `cfg_data` input 8: configuration byte.
- `cfg_ack` output 1: one-cycle acknowledge, the cycle after `cfg_wr`.
- `pwr_limit` input 4: maximum allowed decoded power.
- `chs_power` input 4: decoder power result (combinational from `chs_conf`).
- `chs_mode` input 1: decoder mode result; passed through on `mode_q`.
- `chs_conf` output 8: configuration presented to the decoder.
- `chs_sel` output log2(NCH): index of the channel on `chs_conf`.
- `chs_valid` output 1: decoder outputs are valid for `chs_sel`.
- `mode_q` output 1: `chs_mode` registered at the end of LOAD.
- `ovl` output NCH: sticky per-channel over-limit flags.

## Operation
- Storage: `cfg[NCH]` of 8 bits. A write takes effect at the edge where `cfg_wr` is sampled high. The same write clears `ovl[cfg_ch]`. One write is accepted per cycle and writes are never refused.
- FSM states: IDLE, LOAD, RUN, SWITCH.
- IDLE: `chs_conf`=0, `chs_valid`=0. When `en`=1, go to LOAD with `chs_sel` at its current value.
- LOAD (1 cycle): `chs_conf`=`cfg[chs_sel]`, `chs_valid`=0. At the edge:
  - if `chs_power` > `pwr_limit` (unsigned): set `ovl[chs_sel]` and go to SWITCH;
  - otherwise register `mode_q`, load the dwell counter with DWELL-1, and go to RUN.
- RUN: `chs_conf` held, `chs_valid`=1. The counter decrements each cycle. At 0, go to SWITCH.
- SWITCH (1 cycle): `chs_valid`=0. Set `chs_sel`=(`chs_sel`+1) mod NCH (natural wrap), then go to LOAD.
- `en`=0 is sampled in any state: go to IDLE at the next edge. `chs_sel` keeps its value, so the schedule resumes on the same channel.
- A write to the channel currently in RUN changes `cfg` immediately. `chs_conf` keeps the latched value until the next LOAD of that channel; `chs_conf` is registered at LOAD entry.
- A channel whose `ovl` flag is set is still visited, is rechecked at every LOAD, and keeps the flag until it is rewritten.

## Timing
- Reset values: `cfg`=0 for all channels; `chs_conf`=0, `chs_sel`=0, `chs_valid`=0, `mode_q`=0, `ovl`=0, `cfg_ack`=0; state IDLE; counter 0.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronous).
- Per-channel slot length: DWELL+2 cycles (LOAD + DWELL×RUN + SWITCH). An over-limit slot is 2 cycles.
- `chs_valid` rises 2 cycles after `en` is sampled high from IDLE (IDLE→LOAD→RUN).
- `cfg_ack` follows `cfg_wr` by exactly one cycle and is independent of FSM state.

## Configuration
- `CHS_SKIP_IDLE_EN` defined: in SWITCH, advance to the next index (searching upward with wrap) whose `cfg` is nonzero. If all `cfg` are 0, go to IDLE. In IDLE the FSM stays until some `cfg` is nonzero and `en`=1.
- `CHS_SKIP_IDLE_EN` not defined: every channel is visited in order. A zero configuration is presented like any other value.

## Test plan
- Reset, then write `cfg[0..3]` = 0x0F, 0x87, 0x6E, 0xFF with `pwr_limit`=15, `en`=1, DWELL=16 -> `chs_sel` cycles 0,1,2,3,0; each `chs_valid` window is 16 cycles; `cfg_ack` pulses once per write.
- `pwr_limit`=2 with a decoder model returning power 7 for 0xFF -> `ovl[3]`=1; channel 3 slot is 2 cycles with no `chs_valid`. Rewriting `cfg[3]`=0x00 clears `ovl[3]`.
- Write `cfg[1]`=0x3E while channel 1 is in RUN -> `chs_conf` stays 0x87 until the next LOAD of channel 1, then shows 0x3E.
- `en` dropped mid-RUN on channel 2 -> next cycle IDLE, `chs_conf`=0, `chs_valid`=0. Re-enabling resumes at channel 2.
- With `CHS_SKIP_IDLE_EN` defined and `cfg`={0x0A,0,0,0xB9} -> visit order 0,3,0,3. With all `cfg` 0 -> FSM stays in IDLE.
- Assert `rst_n`=0 asynchronously mid-RUN -> all outputs 0 before the next clock edge; `cfg` and `ovl` are cleared.

Source files
------------

// File: rtl/chs_slot_scheduler.sv
// Round-robin time-slice scheduler sharing one mode/power decoder across NCH channel configs.
// Latency: chs_valid 2 cycles after enable (IDLE->LOAD->RUN); slot = DWELL+2 cycles, over-limit slot = 2.
// Backpressure: none; config writes are always accepted (cfg_ack next cycle). Option: CHS_SKIP_IDLE_EN.
module chs_slot_scheduler #(
   parameter int NCH   = 4,
   parameter int DWELL = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    cfg_wr,
   input  logic [$clog2(NCH)-1:0]  cfg_ch,
   input  logic [7:0]              cfg_data,
   output logic                    cfg_ack,
   input  logic [3:0]              pwr_limit,
   input  logic [3:0]              chs_power,
   input  logic                    chs_mode,
   output logic [7:0]              chs_conf,
   output logic [$clog2(NCH)-1:0]  chs_sel,
   output logic                    chs_valid,
   output logic                    mode_q,
   output logic [NCH-1:0]          ovl
);
   localparam int SW = $clog2(NCH);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, SWITCH} state_t;

   state_t          state;
   logic [7:0]      cnt;
   logic [7:0]      cfg [NCH];
   logic [SW-1:0]   nxt_sel;
   logic            nxt_found;
`ifdef CHS_SKIP_IDLE_EN
   logic [SW-1:0]   cand;
   logic            any_cfg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) cfg[i] <= '0;
      end else if (cfg_wr) begin
         cfg[cfg_ch] <= cfg_data;
      end
   end

   // Next channel to visit; with skipping, the nearest nonzero config upward (wrapping onto itself last).
   always_comb begin
      nxt_sel   = chs_sel + 1'b1;
      nxt_found = 1'b1;
`ifdef CHS_SKIP_IDLE_EN
      cand      = '0;
      any_cfg   = 1'b0;
      nxt_found = 1'b0;
      for (int i = NCH; i >= 1; i--) begin
         cand = chs_sel + SW'(i);
         if (cfg[cand] != 8'd0) begin
            nxt_sel   = cand;
            nxt_found = 1'b1;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (cfg[i] != 8'd0) any_cfg = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         chs_conf  <= '0;
         chs_sel   <= '0;
         chs_valid <= 1'b0;
         mode_q    <= 1'b0;
         ovl       <= '0;
         cfg_ack   <= 1'b0;
      end else begin
         cfg_ack <= cfg_wr;
         if (!en) begin
            state     <= IDLE;
            chs_conf  <= '0;
            chs_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
`ifdef CHS_SKIP_IDLE_EN
                  if (any_cfg) begin
                     state    <= LOAD;
                     chs_conf <= cfg[chs_sel];
                  end
`else
                  state    <= LOAD;
                  chs_conf <= cfg[chs_sel];
`endif
               end
               LOAD: begin
                  if (chs_power > pwr_limit) begin
                     ovl[chs_sel] <= 1'b1;
                     state        <= SWITCH;
                  end else begin
                     mode_q    <= chs_mode;
                     cnt       <= 8'(DWELL - 1);
                     chs_valid <= 1'b1;
                     state     <= RUN;
                  end
               end
               RUN: begin
                  if (cnt == 8'd0) begin
                     chs_valid <= 1'b0;
                     state     <= SWITCH;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               SWITCH: begin
                  if (nxt_found) begin
                     chs_sel  <= nxt_sel;
                     chs_conf <= cfg[nxt_sel];
                     state    <= LOAD;
                  end else begin
                     chs_conf <= '0;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
         // A rewrite clears the sticky flag even if the same edge would have set it.
         if (cfg_wr) ovl[cfg_ch] <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chs_slot_scheduler.sv
// Directed bench for chs_slot_scheduler with a small behavioural decoder (power 7 for 0xFF, else 1).
module tb_chs_slot_scheduler;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       cfg_wr;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_data;
   logic       cfg_ack;
   logic [3:0] pwr_limit;
   logic [3:0] chs_power;
   logic       chs_mode;
   logic [7:0] chs_conf;
   logic [1:0] chs_sel;
   logic       chs_valid;
   logic       mode_q;
   logic [3:0] ovl;

   int checks = 0;
   int fails  = 0;

   chs_slot_scheduler #(.NCH(4), .DWELL(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
      .cfg_data(cfg_data), .cfg_ack(cfg_ack), .pwr_limit(pwr_limit),
      .chs_power(chs_power), .chs_mode(chs_mode), .chs_conf(chs_conf),
      .chs_sel(chs_sel), .chs_valid(chs_valid), .mode_q(mode_q), .ovl(ovl)
   );

   always #5 clk = ~clk;

   assign chs_power = (chs_conf == 8'hFF) ? 4'd7 : 4'd1;
   assign chs_mode  = chs_conf[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [1:0] ch, input logic [7:0] d);
      cfg_wr = 1'b1; cfg_ch = ch; cfg_data = d;
      tick();
      chk("ack_pulse", cfg_ack, 1);
      cfg_wr = 1'b0;
      tick();
      chk("ack_low", cfg_ack, 0);
   endtask

   // Entered just after the edge into LOAD; returns just after the edge into the next LOAD.
   task automatic slot(input logic [1:0] s, input logic [7:0] c, input int len);
      int n;
      n = 0;
      chk("load_sel", chs_sel, s);
      chk("load_conf", chs_conf, c);
      chk("load_valid", chs_valid, 0);
      for (int k = 0; k < 300; k++) begin
         tick();
         if (chs_valid) begin
            n++;
            if (n == 1) chk("mode_q", mode_q, c[7]);
         end else break;
      end
      chk("slot_len", n, len);
      tick();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; en = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_data = '0; pwr_limit = 4'd15;
      tick(); tick();
      chk("rst_conf", chs_conf, 0);
      chk("rst_sel", chs_sel, 0);
      chk("rst_valid", chs_valid, 0);
      chk("rst_mode", mode_q, 0);
      chk("rst_ovl", ovl, 0);
      chk("rst_ack", cfg_ack, 0);
      rst_n = 1'b1;
      tick();

      write(2'd0, 8'h0F); write(2'd1, 8'h87); write(2'd2, 8'h6E); write(2'd3, 8'hFF);
      en = 1'b1;
      tick();
      slot(2'd0, 8'h0F, 16); slot(2'd1, 8'h87, 16); slot(2'd2, 8'h6E, 16);
      slot(2'd3, 8'hFF, 16); slot(2'd0, 8'h0F, 16);

      // Rewrite channel 1 while it is running: the latched value must persist.
      tick();
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_data = 8'h3E;
      tick();
      chk("midrun_ack", cfg_ack, 1);
      chk("midrun_conf", chs_conf, 8'h87);
      chk("midrun_valid", chs_valid, 1);
      cfg_wr = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (chs_valid) n++; else break;
      end
      chk("midrun_rest", n, 14);
      chk("switch_conf", chs_conf, 8'h87);
      tick();
      slot(2'd2, 8'h6E, 16); slot(2'd3, 8'hFF, 16); slot(2'd0, 8'h0F, 16);
      slot(2'd1, 8'h3E, 16);

      pwr_limit = 4'd2;
      slot(2'd2, 8'h6E, 16);
      slot(2'd3, 8'hFF, 0);
      chk("ovl_set", ovl, 4'b1000);
      slot(2'd0, 8'h0F, 16); slot(2'd1, 8'h3E, 16);

      // Drop enable mid-RUN on channel 2.
      tick(); tick(); tick();
      en = 1'b0;
      tick();
      chk("idle_conf", chs_conf, 0);
      chk("idle_valid", chs_valid, 0);
      chk("idle_sel", chs_sel, 2);
      chk("ovl_sticky", ovl, 4'b1000);
      write(2'd3, 8'h00);
      chk("ovl_clr", ovl, 0);
      write(2'd1, 8'hBE);
      chk("idle_hold_sel", chs_sel, 2);
      en = 1'b1;
      tick();
      slot(2'd2, 8'h6E, 16);
`ifndef CHS_SKIP_IDLE_EN
      slot(2'd3, 8'h00, 16);
`endif
      slot(2'd0, 8'h0F, 16);
      tick();
      chk("prerst_valid", chs_valid, 1);
      chk("prerst_sel", chs_sel, 1);
      chk("prerst_conf", chs_conf, 8'hBE);
      chk("prerst_mode", mode_q, 1);

      // Asynchronous reset mid-RUN, observed before the next clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_conf", chs_conf, 0);
      chk("arst_sel", chs_sel, 0);
      chk("arst_valid", chs_valid, 0);
      chk("arst_mode", mode_q, 0);
      chk("arst_ovl", ovl, 0);
      chk("arst_ack", cfg_ack, 0);
      #2 rst_n = 1'b1;
      tick();
`ifndef CHS_SKIP_IDLE_EN
      chk("post_load_conf", chs_conf, 0);
      chk("post_load_valid", chs_valid, 0);
      tick();
      chk("post_run_valid", chs_valid, 1);
      chk("post_run_sel", chs_sel, 0);
`else
      tick(); tick();
      chk("allzero_valid", chs_valid, 0);
      chk("allzero_conf", chs_conf, 0);
      en = 1'b0;
      tick();
      write(2'd0, 8'h0A);
      write(2'd3, 8'hB9);
      en = 1'b1;
      tick();
      slot(2'd0, 8'h0A, 16); slot(2'd3, 8'hB9, 16);
      slot(2'd0, 8'h0A, 16); slot(2'd3, 8'hB9, 16);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
